// File: rtl/mc_pkg.sv
// Types and defaults shared between the CPU-side request master and the memory controller.
package mc_pkg;

    localparam int MC_ADDR_W = 4;
    localparam int MC_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    typedef struct packed {
        logic                 write;
        logic [MC_ADDR_W-1:0] addr;
        logic [MC_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_request_master_if.sv
// CPU command/response channel plus the MEMR/MEMW <-> CPU_RD/CPU_WR controller handshake.
interface mem_request_master_if
    import mc_pkg::*;
#(
    parameter int ADDR_W = MC_ADDR_W,
    parameter int DATA_W = MC_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              MEMR;
    logic              MEMW;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              CPU_RD;
    logic              CPU_WR;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, mem_rdata, CPU_RD, CPU_WR,
        output cmd_ready, MEMR, MEMW, mem_addr, mem_wdata,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, mem_rdata, CPU_RD, CPU_WR,
        input  cmd_ready, MEMR, MEMW, mem_addr, mem_wdata,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/mrm_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module mrm_cmd_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only; the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_request_master.sv
// CPU-side initiator for the MEMR/MEMW request, CPU_RD/CPU_WR acknowledge handshake.
// Optional ack timeout enabled by defining MRM_TIMEOUT_EN.
module mem_request_master
    import mc_pkg::*;
#(
    parameter int ADDR_W      = MC_ADDR_W,
    parameter int DATA_W      = MC_DATA_W,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic CLK,
    input  logic RST,
    mem_request_master_if.master bus
);
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_rec_t;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mem_request_master: CMD_DEPTH must be a power of 2 >= 2, TIMEOUT_CYC >= 1");
    end

    cmd_rec_t          fifo_din;
    cmd_rec_t          fifo_dout;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    mc_state_t         state_q;
    mc_state_t         state_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              memr_q;
    logic              memw_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              ack_match;
    logic              req_end;

    assign fifo_din  = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign fifo_push = bus.cmd_valid && !fifo_full;

    mrm_cmd_fifo #(
        .WIDTH ($bits(cmd_rec_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Only the acknowledge matching the outstanding request type completes it.
    assign ack_match = write_q ? bus.CPU_WR : bus.CPU_RD;

`ifdef MRM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_fire;
    logic          rsp_err_q;

    assign tmo_fire = (state_q == REQ) && !ack_match && (tmo_cnt == TMO_LAST);
    assign req_end  = ack_match || tmo_fire;

    always_ff @(posedge CLK) begin
        if (RST)
            tmo_cnt <= '0;
        else if (fifo_pop)
            tmo_cnt <= '0;
        else if (state_q == REQ)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            rsp_err_q <= 1'b0;
        else
            rsp_err_q <= tmo_fire;
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign req_end     = ack_match;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (req_end)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            memr_q      <= 1'b0;
            memw_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                write_q <= fifo_dout.write;
                addr_q  <= fifo_dout.addr;
                wdata_q <= fifo_dout.wdata;
            end
            // Request rises with the pop and stays up until the cycle after completion.
            memr_q      <= fifo_pop ? !fifo_dout.write : (memr_q && state_d == REQ);
            memw_q      <= fifo_pop ?  fifo_dout.write : (memw_q && state_d == REQ);
            rsp_valid_q <= (state_q == REQ) && (state_d == DONE);
            if ((state_q == REQ) && (state_d == DONE)) begin
                rsp_write_q <= write_q;
                rsp_rdata_q <= (ack_match && !write_q) ? bus.mem_rdata : '0;
            end
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.MEMR      = memr_q;
    assign bus.MEMW      = memw_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_request_master.sv
// Randomized bench for mem_request_master with a transaction-level reference model.
// Define MRM_TIMEOUT_EN for both RTL and bench to exercise the ack timeout.
module tb_mem_request_master;
    import mc_pkg::*;

    localparam int ADDR_W      = MC_ADDR_W;
    localparam int DATA_W      = MC_DATA_W;
    localparam int CMD_DEPTH   = 4;
    localparam int TIMEOUT_CYC = 15;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_request_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_request_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CMD_DEPTH   (CMD_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: commands still to offer, commands accepted but not yet issued,
    // the outstanding request and the response expected in the next cycle.
    cmd_t              send_q[$];
    cmd_t              q_acc[$];
    cmd_t              cur;
    bit                in_req = 0;
    bit                exp_rise = 0;
    bit                exp_rsp = 0;
    bit                exp_write = 0;
    logic [DATA_W-1:0] exp_rdata = '0;
    bit                exp_err = 0;
    int                wait_cnt = 0;
    int                age = 0;

    // Stimulus policy knobs
    bit                ack_en = 1;
    int                fixed_delay = -1;
    int                wrong_pct = 0;
    int                idle_ack_pct = 0;
    int                cmd_pct = 100;
    bit                rdata_fix_en = 0;
    logic [DATA_W-1:0] rdata_fix = '0;

    int                n_rsp = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] last_rdata = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        send_q.delete();
        q_acc.delete();
        in_req   = 0;
        exp_rise = 0;
        exp_rsp  = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.CPU_RD    = 1'b0;
        bus.CPU_WR    = 1'b0;
        @(posedge CLK);
        #1;
        check_val("rst_memr",      bus.MEMR,      0);
        check_val("rst_memw",      bus.MEMW,      0);
        check_val("rst_addr",      bus.mem_addr,  0);
        check_val("rst_wdata",     bus.mem_wdata, 0);
        check_val("rst_rsp_valid", bus.rsp_valid, 0);
        check_val("rst_rsp_write", bus.rsp_write, 0);
        check_val("rst_rsp_rdata", bus.rsp_rdata, 0);
        check_val("rst_rsp_err",   bus.rsp_err,   0);
        check_val("rst_busy",      bus.busy,      0);
        check_val("rst_cmd_ready", bus.cmd_ready, 1);
        RST = 1'b0;
        clear_model();
    endtask

    // One clock: observe and check outputs, then drive inputs for this cycle.
    task automatic cycle();
        logic req_hi;
        logic rise;
        @(posedge CLK);
        #1;
        req_hi = bus.MEMR | bus.MEMW;
        rise   = req_hi && !in_req;
        check_val("req_onehot", bus.MEMR & bus.MEMW, 0);

        if (in_req) begin
            check_val("hold_memr", bus.MEMR, !cur.write);
            check_val("hold_memw", bus.MEMW, cur.write);
            check_val("hold_addr", bus.mem_addr, cur.addr);
            if (cur.write) check_val("hold_wdata", bus.mem_wdata, cur.wdata);
        end else begin
            check_val("req_start", rise, exp_rise);
            if (rise) begin
                if (q_acc.size() == 0) begin
                    check_val("req_unexpected", 1, 0);
                end else begin
                    cur = q_acc.pop_front();
                    check_val("req_type", bus.MEMW, cur.write);
                    check_val("req_addr", bus.mem_addr, cur.addr);
                    if (cur.write) check_val("req_wdata", bus.mem_wdata, cur.wdata);
                end
                in_req   = 1;
                age      = 1;
                wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
            end
        end

        check_val("rsp_valid", bus.rsp_valid, exp_rsp);
        if (exp_rsp) begin
            check_val("rsp_write", bus.rsp_write, exp_write);
            check_val("rsp_rdata", bus.rsp_rdata, exp_rdata);
            check_val("rsp_err",   bus.rsp_err,   exp_err);
            check_val("rsp_gap",   req_hi,        0);
        end
        if (bus.rsp_valid) begin
            n_rsp++;
            last_rdata = bus.rsp_rdata;
            if (bus.rsp_err) n_err++;
        end
        check_val("cmd_ready", bus.cmd_ready, q_acc.size() < CMD_DEPTH);
        check_val("busy", bus.busy, req_hi || exp_rsp || q_acc.size() != 0);
        exp_rise = !req_hi && !exp_rsp && q_acc.size() != 0;

        // Acknowledge side
        exp_rsp = 0;
        bus.CPU_RD    = 1'b0;
        bus.CPU_WR    = 1'b0;
        bus.mem_rdata = DATA_W'($urandom);
        if (in_req) begin
            if (ack_en && wait_cnt == 0) begin
                if (cur.write) begin
                    bus.CPU_WR = 1'b1;
                end else begin
                    bus.CPU_RD    = 1'b1;
                    bus.mem_rdata = rdata_fix_en ? rdata_fix : DATA_W'($urandom);
                end
                exp_rsp   = 1;
                exp_write = cur.write;
                exp_rdata = cur.write ? '0 : bus.mem_rdata;
                exp_err   = 0;
                in_req    = 0;
            end else begin
                if (wait_cnt > 0) wait_cnt--;
                if ($urandom_range(0, 99) < wrong_pct) begin
                    if (cur.write) bus.CPU_RD = 1'b1;
                    else           bus.CPU_WR = 1'b1;
                end
`ifdef MRM_TIMEOUT_EN
                if (age == TIMEOUT_CYC) begin
                    exp_rsp   = 1;
                    exp_write = cur.write;
                    exp_rdata = '0;
                    exp_err   = 1;
                    in_req    = 0;
                end
`endif
                age++;
            end
        end else if ($urandom_range(0, 99) < idle_ack_pct) begin
            if ($urandom_range(0, 1) == 1) bus.CPU_RD = 1'b1;
            else                            bus.CPU_WR = 1'b1;
        end

        // Command side
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = ADDR_W'($urandom);
        bus.cmd_wdata = DATA_W'($urandom);
        if (send_q.size() != 0 && $urandom_range(0, 99) < cmd_pct) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = send_q[0].write;
            bus.cmd_addr  = send_q[0].addr;
            bus.cmd_wdata = send_q[0].wdata;
            if (bus.cmd_ready) q_acc.push_back(send_q.pop_front());
        end
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((send_q.size() != 0 || q_acc.size() != 0 || in_req || exp_rsp || exp_rise)
               && n < max_cyc) begin
            cycle();
            n++;
        end
        check_val("drain_bound", n < max_cyc, 1);
        cycle();
    endtask

    initial begin
        int   r0;
        int   n;
        cmd_t c;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.mem_rdata = '0;
        bus.CPU_RD    = 1'b0;
        bus.CPU_WR    = 1'b0;
        repeat (2) @(posedge CLK);
        do_reset();

        // Write, acked two cycles after MEMW rises
        fixed_delay = 2;
        r0 = n_rsp;
        send_q.push_back('{write: 1'b1, addr: 4'd3, wdata: 16'hA5A5});
        drain(50);
        check_val("t1_rsp_count", n_rsp, r0 + 1);

        // Read with known data
        fixed_delay  = 1;
        rdata_fix_en = 1;
        rdata_fix    = 16'h1234;
        r0 = n_rsp;
        send_q.push_back('{write: 1'b0, addr: 4'd7, wdata: 16'h0000});
        drain(50);
        check_val("t2_rsp_count", n_rsp, r0 + 1);
        check_val("t2_rdata", last_rdata, 16'h1234);
        rdata_fix_en = 0;

        // Fill: one command goes to REQ, four fill the FIFO, the sixth is held
        ack_en = 0;
        fixed_delay = 0;
        for (int i = 0; i < 6; i++) send_q.push_back('{write: i[0], addr: ADDR_W'(i + 8), wdata: DATA_W'(16'h1000 + i)});
        repeat (12) cycle();
        check_val("t3_held", send_q.size(), 1);
        check_val("t3_ready", bus.cmd_ready, 0);
        ack_en = 1;
        drain(200);

        // Wrong-type acks while a read waits
        fixed_delay = 3;
        wrong_pct   = 100;
        send_q.push_back('{write: 1'b0, addr: 4'd9, wdata: 16'h0});
        send_q.push_back('{write: 1'b1, addr: 4'd2, wdata: 16'hBEEF});
        drain(80);
        wrong_pct = 0;

        // Reset during REQ with two commands queued
        ack_en = 0;
        for (int i = 0; i < 3; i++) send_q.push_back('{write: 1'b0, addr: ADDR_W'(i + 1), wdata: 16'h0});
        n = 0;
        while (!(in_req && q_acc.size() == 2 && send_q.size() == 0) && n < 20) begin
            cycle();
            n++;
        end
        check_val("t5_setup", n < 20, 1);
        do_reset();
        ack_en = 1;
        idle_ack_pct = 50;
        r0 = n_rsp;
        repeat (8) cycle();
        check_val("t5_no_rsp", n_rsp, r0);
        idle_ack_pct = 0;

`ifdef MRM_TIMEOUT_EN
        // No ack: the timeout completes the read with an error, the next command still issues
        ack_en = 0;
        r0 = n_err;
        send_q.push_back('{write: 1'b0, addr: 4'd5, wdata: 16'h0});
        n = 0;
        while (n_err == r0 && n < 40) begin
            cycle();
            n++;
        end
        check_val("t6_err_rsp", n_err, r0 + 1);
        ack_en = 1;
        r0 = n_rsp;
        send_q.push_back('{write: 1'b1, addr: 4'd6, wdata: 16'h5A5A});
        drain(50);
        check_val("t6_next_rsp", n_rsp, r0 + 1);
`endif

        // Randomized traffic
        fixed_delay  = -1;
        wrong_pct    = 30;
        idle_ack_pct = 20;
        cmd_pct      = 60;
        r0 = n_rsp;
        for (int i = 0; i < 150; i++) begin
            c.write = 1'($urandom);
            c.addr  = ADDR_W'($urandom);
            c.wdata = DATA_W'($urandom);
            send_q.push_back(c);
        end
        drain(6000);
        check_val("rand_rsp_count", n_rsp, r0 + 150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
